// File: rtl/soc_membus_arbiter_pkg.sv
// Shared types and constants for the SoC_MemBus arbiter and its helpers.
package soc_membus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    localparam logic [1:0] OWNER_NONE = 2'b00;
    localparam logic [1:0] OWNER_M0   = 2'b01;
    localparam logic [1:0] OWNER_M1   = 2'b10;

    // Read data returned to a master whose transaction was aborted by the watchdog.
    localparam logic [31:0] TIMEOUT_READ_DATA = 32'hDEAD_BEEF;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

endpackage

// File: rtl/soc_membus_arbiter_if.sv
// SoC_MemBus point-to-point link.
// Handshake: the master raises req with addr/write_en/write_data/byte_en and
// holds them stable until it sees valid; the slave pulses valid for exactly one
// cycle per request (with read_data for reads); the master drops req in the
// cycle after valid. There is no back-pressure beyond withholding valid.
interface SoC_MemBus;
    import soc_membus_pkg::*;

    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              write_en;
    logic [DATA_W-1:0] write_data;
    logic [BE_W-1:0]   byte_en;
    logic              valid;
    logic [DATA_W-1:0] read_data;

    modport Master (output req, addr, write_en, write_data, byte_en,
                    input  valid, read_data);
    modport Slave  (input  req, addr, write_en, write_data, byte_en,
                    output valid, read_data);
endinterface

// File: rtl/soc_arb_watchdog.sv
// Saturating cycle counter that flags a transaction which has waited too long.
// TIMEOUT_CYCLES = 0 disables counting entirely and expired never asserts.
module soc_arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = 11
) (
    input  logic clk,
    input  logic res,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam logic [CNT_WIDTH-1:0] LIMIT =
        (TIMEOUT_CYCLES == 0) ? '0 : CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [CNT_WIDTH-1:0] cnt;

    // Count enabled cycles, stopping at LIMIT so the value never wraps.
    always_ff @(posedge clk) begin
        if (!res) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (TIMEOUT_CYCLES != 0) && (cnt != LIMIT)) begin
            cnt <= cnt + CNT_WIDTH'(1);
        end
    end

    assign expired = (TIMEOUT_CYCLES != 0) && en && (cnt == LIMIT);

endmodule

// File: rtl/soc_membus_arbiter.sv
// Two-master arbiter for one SoC_MemBus slave: m0 = CPU, m1 = UART bridge.
// One complete transaction per grant; a watchdog aborts hung transactions.
module soc_membus_arbiter
    import soc_membus_pkg::*;
#(
    parameter int PRIO_MODE      = 0,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = 11
) (
    input  logic             clk,
    input  logic             res,
    SoC_MemBus.Slave         m0,
    SoC_MemBus.Slave         m1,
    SoC_MemBus.Master        s,
    output logic [1:0]       owner,
    output logic             timeout_err
);
    arb_state_t state_q, state_d;
    logic       last_grant_q;   // 1 = m1 was granted last, 0 = m0
    logic       wd_en, wd_clr, wd_expired;

    // The watchdog runs only while a grant is open and restarts on completion.
    assign wd_en  = (state_q != IDLE);
    assign wd_clr = (state_q == IDLE) || s.valid;

    soc_arb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_WIDTH      (CNT_WIDTH)
    ) u_watchdog (
        .clk     (clk),
        .res     (res),
        .clr     (wd_clr),
        .en      (wd_en),
        .expired (wd_expired)
    );

    // State register and round-robin history, updated when a grant opens.
    always_ff @(posedge clk) begin
        if (!res) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && state_d == GNT0) begin
                last_grant_q <= 1'b0;
            end else if (state_q == IDLE && state_d == GNT1) begin
                last_grant_q <= 1'b1;
            end
        end
    end

    // Next-state selection plus the routing mux between owner and slave.
    always_comb begin
        state_d      = state_q;
        owner        = OWNER_NONE;
        timeout_err  = 1'b0;
        s.req        = 1'b0;
        s.addr       = '0;
        s.write_en   = 1'b0;
        s.write_data = '0;
        s.byte_en    = '0;
        m0.valid     = 1'b0;
        m0.read_data = '0;
        m1.valid     = 1'b0;
        m1.read_data = '0;

        case (state_q)
            IDLE: begin
                if (m0.req && m1.req) begin
                    // Fixed priority favours the bridge; round-robin alternates.
                    state_d = ((PRIO_MODE != 0) || !last_grant_q) ? GNT1 : GNT0;
                end else if (m0.req) begin
                    state_d = GNT0;
                end else if (m1.req) begin
                    state_d = GNT1;
                end
            end
            GNT0: begin
                owner        = OWNER_M0;
                s.req        = m0.req;
                s.addr       = m0.addr;
                s.write_en   = m0.write_en;
                s.write_data = m0.write_data;
                s.byte_en    = m0.byte_en;
                m0.valid     = s.valid;
                m0.read_data = s.read_data;
                if (s.valid) begin
                    state_d = IDLE;
                end else if (wd_expired) begin
                    s.req        = 1'b0;
                    m0.valid     = 1'b1;
                    m0.read_data = TIMEOUT_READ_DATA;
                    timeout_err  = 1'b1;
                    state_d      = IDLE;
                end
            end
            GNT1: begin
                owner        = OWNER_M1;
                s.req        = m1.req;
                s.addr       = m1.addr;
                s.write_en   = m1.write_en;
                s.write_data = m1.write_data;
                s.byte_en    = m1.byte_en;
                m1.valid     = s.valid;
                m1.read_data = s.read_data;
                if (s.valid) begin
                    state_d = IDLE;
                end else if (wd_expired) begin
                    s.req        = 1'b0;
                    m1.valid     = 1'b1;
                    m1.read_data = TIMEOUT_READ_DATA;
                    timeout_err  = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
